// File: rtl/square_pos_ctrl.sv
// square_pos_ctrl
//   Upstream stage of the square drawing block for the 96x64 OLED. Each raw
//   pushbutton passes through a two-flop synchroniser and a debounce counter.
//   A held direction moves the square by STEP_PX pixels, once when it is
//   first pressed and then every STEP_DIV cycles while it stays held. A
//   press on the centre button cycles the square through three sizes. The
//   geometry is kept in shadow registers. The outputs load those registers
//   only on frame_begin, so a frame is never drawn with mixed geometry.
//
//   Configuration macro: SQUARE_WRAP_EN. When it is defined, a step past an
//   edge wraps to the opposite side instead of saturating. A resize always
//   clamps.
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   btn_up/down    in   raw buttons, Y decreasing / increasing
//   btn_left/right in   raw buttons, X decreasing / increasing
//   btn_centre     in   raw button, cycles the square size
//   frame_begin    in   one-cycle pulse at pixel_index 0, commits geometry
//   X_coord_start  out  committed left edge
//   Y_coord_start  out  committed top edge
//   length         out  committed length (inclusive extent)
//   moving         out  high while any debounced direction is held
module square_pos_ctrl #(
  parameter int SCREEN_W     = 96,
  parameter int SCREEN_H     = 64,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int STEP_DIV     = 2500000,
  parameter int STEP_PX      = 2,
  parameter int LEN0         = 7,
  parameter int LEN1         = 15,
  parameter int LEN2         = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_centre,
  input  logic       frame_begin,
  output logic [7:0] X_coord_start,
  output logic [7:0] Y_coord_start,
  output logic [7:0] length,
  output logic       moving
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int ST_W = $clog2(STEP_DIV + 1);
  localparam logic [7:0] X_RST = 8'((SCREEN_W - 1 - LEN0) / 2);
  localparam logic [7:0] Y_RST = 8'((SCREEN_H - 1 - LEN0) / 2);
  localparam logic signed [8:0] STEP_S = 9'(STEP_PX);
  localparam logic signed [8:0] XLIM_S = 9'(SCREEN_W - 1);
  localparam logic signed [8:0] YLIM_S = 9'(SCREEN_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD} state_t;

  // Saturate a signed coordinate into the range [0, mx].
  function automatic logic [7:0] clamp_f(input logic signed [8:0] v, input logic signed [8:0] mx);
    logic [7:0] r;
    if (v < 9'sd0) r = 8'd0;
    else if (v > mx) r = mx[7:0];
    else r = v[7:0];
    return r;
  endfunction

`ifdef SQUARE_WRAP_EN
  // A step overshoots by at most STEP_PX, so a single wrap is enough.
  function automatic logic [7:0] step_fit_f(input logic signed [8:0] v, input logic signed [8:0] mx);
    logic signed [8:0] t;
    if (v < 9'sd0) t = mx + 9'sd1 + v;
    else if (v > mx) t = v - mx - 9'sd1;
    else t = v;
    return t[7:0];
  endfunction
`else
  function automatic logic [7:0] step_fit_f(input logic signed [8:0] v, input logic signed [8:0] mx);
    return clamp_f(v, mx);
  endfunction
`endif

  // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 centre.
  logic [4:0] btn_raw;
  assign btn_raw = {btn_centre, btn_right, btn_left, btn_down, btn_up};

  logic [4:0]      sync1_q, sync2_q, lvl_q, lvl_d;
  logic [DB_W-1:0] db_cnt_q [5];
  logic [DB_W-1:0] db_cnt_d [5];
  state_t          state_q, state_d;
  logic [ST_W-1:0] step_cnt_q, step_cnt_d;
  logic            do_step, any_dir, moving_q;
  logic signed [8:0] dx, dy, x_max, y_max;
  logic [1:0]      size_q, size_d;
  logic [7:0]      len_sh_q, len_d, x_sh_q, x_sh_d, y_sh_q, y_sh_d, x_rc, y_rc;
  logic [7:0]      x_out_q, y_out_q, len_out_q;

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 5'd0;
      sync2_q <= 5'd0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the level flips on the DEBOUNCE_CYC-th consecutive differing sample.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          lvl_d[i]    = ~lvl_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Debounce counters and debounced levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 5'd0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      lvl_q <= lvl_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Per-axis step. An opposing pair held together cancels on that axis.
  always_comb begin
    any_dir = |lvl_q[3:0];
    if (lvl_q[3] & ~lvl_q[2]) dx = STEP_S;
    else if (lvl_q[2] & ~lvl_q[3]) dx = -STEP_S;
    else dx = 9'sd0;
    if (lvl_q[1] & ~lvl_q[0]) dy = STEP_S;
    else if (lvl_q[0] & ~lvl_q[1]) dy = -STEP_S;
    else dy = 9'sd0;
  end

  // Auto-repeat FSM. HOLD leaves on the count of 1, so steps are STEP_DIV cycles apart.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    do_step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_dir) state_d = S_STEP;
        else state_d = S_IDLE;
      end
      S_STEP: begin
        do_step    = 1'b1;
        step_cnt_d = ST_W'(STEP_DIV - 1);
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (!any_dir) begin
          state_d    = S_IDLE;
          step_cnt_d = '0;
        end else if (step_cnt_q <= ST_W'(1)) begin
          state_d    = S_STEP;
          step_cnt_d = '0;
        end else begin
          step_cnt_d = step_cnt_q - ST_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        step_cnt_d = '0;
      end
    endcase
  end

  // Shadow geometry. A resize re-clamps first, then any step uses the new length.
  always_comb begin
    if (lvl_d[4] & ~lvl_q[4]) begin
      if (size_q == 2'd2) size_d = 2'd0;
      else size_d = size_q + 2'd1;
    end else begin
      size_d = size_q;
    end
    case (size_d)
      2'd0:    len_d = 8'(LEN0);
      2'd1:    len_d = 8'(LEN1);
      2'd2:    len_d = 8'(LEN2);
      default: len_d = 8'(LEN0);
    endcase
    x_max = XLIM_S - $signed({1'b0, len_d});
    y_max = YLIM_S - $signed({1'b0, len_d});
    x_rc  = clamp_f($signed({1'b0, x_sh_q}), x_max);
    y_rc  = clamp_f($signed({1'b0, y_sh_q}), y_max);
    if (do_step) begin
      x_sh_d = step_fit_f($signed({1'b0, x_rc}) + dx, x_max);
      y_sh_d = step_fit_f($signed({1'b0, y_rc}) + dy, y_max);
    end else begin
      x_sh_d = x_rc;
      y_sh_d = y_rc;
    end
  end

  // State, shadow registers, and the frame-synchronous output commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_cnt_q <= '0;
      moving_q   <= 1'b0;
      size_q     <= 2'd0;
      len_sh_q   <= 8'(LEN0);
      x_sh_q     <= X_RST;
      y_sh_q     <= Y_RST;
      x_out_q    <= X_RST;
      y_out_q    <= Y_RST;
      len_out_q  <= 8'(LEN0);
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      moving_q   <= (state_d != S_IDLE);
      size_q     <= size_d;
      len_sh_q   <= len_d;
      x_sh_q     <= x_sh_d;
      y_sh_q     <= y_sh_d;
      if (frame_begin) begin
        // These take the pre-update shadow; a change made this cycle waits one frame.
        x_out_q   <= x_sh_q;
        y_out_q   <= y_sh_q;
        len_out_q <= len_sh_q;
      end
    end
  end

  assign X_coord_start = x_out_q;
  assign Y_coord_start = y_out_q;
  assign length        = len_out_q;
  assign moving        = moving_q;

endmodule

// File: tb/tb_square_pos_ctrl.sv
`timescale 1ns/1ps
module tb_square_pos_ctrl;
  localparam int DB = 4;
  localparam int SD = 10;
  localparam int SW = 96;
  localparam int SH = 64;
  localparam logic [4:0] UP = 5'b00001, DOWN = 5'b00010, LEFT = 5'b00100,
                         RIGHT = 5'b01000, CENTRE = 5'b10000, NONE = 5'b00000;
`ifdef SQUARE_WRAP_EN
  localparam int XS = 5, XR1 = 5, XR2 = 5;
`else
  localparam int XS = 88, XR1 = 80, XR2 = 72;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_centre = 1'b0;
  logic frame_begin = 1'b0;
  logic [7:0] X_coord_start, Y_coord_start, length;
  logic moving;

  square_pos_ctrl #(.DEBOUNCE_CYC(DB), .STEP_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_centre(btn_centre),
    .frame_begin(frame_begin), .X_coord_start(X_coord_start),
    .Y_coord_start(Y_coord_start), .length(length), .moving(moving));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int ex, input int ey, input int el, input int em);
    check({name, ".X"}, int'(X_coord_start), ex);
    check({name, ".Y"}, int'(Y_coord_start), ey);
    check({name, ".len"}, int'(length), el);
    check({name, ".moving"}, int'(moving), em);
  endtask

  task automatic drive(input logic [4:0] b, input logic fb);
    {btn_centre, btn_right, btn_left, btn_down, btn_up} = b;
    frame_begin = fb;
  endtask

  // ---------------- reference model ----------------
  // Geometry and auto-repeat schedule written from the behavioural rules:
  // a held direction steps one cycle after its debounced press, then every SD cycles.
  int m_cyc, m_next, m_x, m_y, m_len, m_size, m_ox, m_oy, m_ol;
  bit m_mov;
  bit [4:0] m_d1, m_d2, m_lvl;
  int m_run [5];
  int lens [3];

  function automatic int clampi(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  function automatic int fit(input int v, input int mx);
`ifdef SQUARE_WRAP_EN
    return (v < 0) ? (mx + 1 + v) : ((v > mx) ? (v - mx - 1) : v);
`else
    return clampi(v, mx);
`endif
  endfunction

  task automatic model_init();
    m_cyc = 0; m_next = 0; m_mov = 1'b0;
    m_x = 44; m_y = 28; m_len = 7; m_size = 0;
    m_ox = 44; m_oy = 28; m_ol = 7;
    m_d1 = '0; m_d2 = '0; m_lvl = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    lens[0] = 7; lens[1] = 15; lens[2] = 23;
  endtask

  task automatic model_edge(input bit [4:0] raw, input bit fb);
    bit [4:0] nl;
    bit step;
    int dx, dy;
    if (fb) begin m_ox = m_x; m_oy = m_y; m_ol = m_len; end
    nl = m_lvl;
    for (int i = 0; i < 5; i++) begin
      if (m_d2[i] != m_lvl[i]) begin
        if (m_run[i] + 1 >= DB) begin nl[i] = ~m_lvl[i]; m_run[i] = 0; end
        else m_run[i] = m_run[i] + 1;
      end else m_run[i] = 0;
    end
    if (nl[4] && !m_lvl[4]) begin
      m_size = (m_size + 1) % 3;
      m_len = lens[m_size];
      m_x = clampi(m_x, SW - 1 - m_len);
      m_y = clampi(m_y, SH - 1 - m_len);
    end
    step = m_mov && (m_cyc == m_next);
    if (step) begin
      dx = (m_lvl[3] && !m_lvl[2]) ? 2 : ((m_lvl[2] && !m_lvl[3]) ? -2 : 0);
      dy = (m_lvl[1] && !m_lvl[0]) ? 2 : ((m_lvl[0] && !m_lvl[1]) ? -2 : 0);
      m_x = fit(m_x + dx, SW - 1 - m_len);
      m_y = fit(m_y + dy, SH - 1 - m_len);
      m_next = m_cyc + SD;
    end else if (m_mov) begin
      m_mov = |m_lvl[3:0];
    end else if (|m_lvl[3:0]) begin
      m_mov = 1'b1;
      m_next = m_cyc + 1;
    end
    m_lvl = nl;
    m_d2 = m_d1;
    m_d1 = raw;
    m_cyc++;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0] btn;
    logic       fb;     // applied on the last cycle of the entry only
    int         cyc;
    int         ex, ey, el, em;
  } vec_t;
  vec_t tbl [17];

  initial begin
    tbl[0]  = '{NONE,        1'b1, 1,   44, 28, 7,  0};
    tbl[1]  = '{RIGHT,       1'b0, 50,  44, 28, 7,  1};
    tbl[2]  = '{RIGHT,       1'b1, 1,   54, 28, 7,  1};
    tbl[3]  = '{NONE,        1'b0, 12,  54, 28, 7,  0};
    tbl[4]  = '{NONE,        1'b1, 1,   54, 28, 7,  0};
    tbl[5]  = '{LEFT,        1'b0, 3,   54, 28, 7,  0};
    tbl[6]  = '{NONE,        1'b1, 10,  54, 28, 7,  0};
    tbl[7]  = '{RIGHT,       1'b0, 200, 54, 28, 7,  1};
    tbl[8]  = '{NONE,        1'b1, 12,  XS, 28, 7,  0};
    tbl[9]  = '{CENTRE,      1'b0, 8,   XS, 28, 7,  0};
    tbl[10] = '{NONE,        1'b1, 8,   XR1, 28, 15, 0};
    tbl[11] = '{CENTRE,      1'b0, 8,   XR1, 28, 15, 0};
    tbl[12] = '{NONE,        1'b1, 8,   XR2, 28, 23, 0};
    tbl[13] = '{CENTRE,      1'b0, 8,   XR2, 28, 23, 0};
    tbl[14] = '{NONE,        1'b1, 8,   XR2, 28, 7,  0};
    tbl[15] = '{UP | DOWN,   1'b0, 30,  XR2, 28, 7,  1};
    tbl[16] = '{UP | DOWN,   1'b1, 1,   XR2, 28, 7,  1};

    // reset state, asynchronously applied
    #2 rst_n = 1'b0;
    #1 check_all("reset", 44, 28, 7, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) begin
        drive(tbl[i].btn, (c == tbl[i].cyc - 1) ? tbl[i].fb : 1'b0);
        @(posedge clk);
        @(negedge clk);
      end
      frame_begin = 1'b0;
      check_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].el, tbl[i].em);
    end

    // Reset asserted mid-hold clears the outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_all("rst_midhold", 44, 28, 7, 0);
    drive(NONE, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First step lands on the same edge as a commit: the commit takes the old position.
    for (int c = 0; c < 8; c++) begin
      drive(RIGHT, c == 7);
      @(posedge clk);
      @(negedge clk);
    end
    check_all("coincide", 44, 28, 7, 1);
    drive(RIGHT, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_all("coincide_next", 46, 28, 7, 1);

    // ---------------- randomized run against the model ----------------
    drive(NONE, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_init();
    for (int s = 0; s < 60; s++) begin
      logic [4:0] b;
      int len;
      b = 5'($urandom_range(0, 31));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 120) : $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        drive(b, $urandom_range(0, 5) == 0);
        @(posedge clk);
        model_edge(b, frame_begin);
        @(negedge clk);
        check_all("rand", m_ox, m_oy, m_ol, int'(m_mov));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
